// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared constants, line type and loader state encoding
package encoder_pkg;

    localparam int LINE_W = 25;
    localparam int DEPTH  = 64;
    localparam int AW     = 6;

    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [1:0] {
        LOAD,
        START,
        RUN
    } loader_state_t;

    // Even parity over payload plus parity bit: 1 means the line is corrupt.
    function automatic logic line_par_bad(input line_t data, input logic par);
        return (^data) ^ par;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - DEPTH x LINE_W line store, synchronous write, asynchronous read
module line_buffer
    import encoder_pkg::*;
(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  line_t         wdata,
    input  logic [AW-1:0] raddr,
    output line_t         rdata
);

    line_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/line_loader.sv
// rtl/line_loader.sv - frame loader in front of encoder_top; LOADER_PARITY_EN enables line parity check
module line_loader
    import encoder_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  line_t         in_data,
    input  logic          in_par,
    input  logic [AW-1:0] cnt_value,
    input  logic          donee,
    output logic          start,
    output line_t         line_in,
    output logic          busy,
    output logic [7:0]    frame_cnt,
    output logic          par_err
);

    loader_state_t state, state_nxt;
    logic [AW-1:0] wr_ptr;
    logic          accept;
    logic          frame_done;

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        start      = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && wr_ptr == AW'(DEPTH - 1)) begin
                    state_nxt = START;
                end
            end
            START: begin
                start     = 1'b1;
                busy      = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (donee) begin
                    state_nxt  = LOAD;
                    frame_done = 1'b1;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    // in_ready is purely state-decoded, so writes can only happen in LOAD.
    assign accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= LOAD;
            wr_ptr    <= '0;
            frame_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (frame_done) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

`ifdef LOADER_PARITY_EN
    logic par_err_q;

    // The first line of a frame restarts the sticky flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            par_err_q <= 1'b0;
        end else if (accept) begin
            par_err_q <= ((wr_ptr == '0) ? 1'b0 : par_err_q) | line_par_bad(in_data, in_par);
        end
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0 & in_par;
`endif

    line_buffer u_buf (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (cnt_value),
        .rdata (line_in)
    );

endmodule

// File: tb/tb_line_loader.sv
// tb/tb_line_loader.sv - randomized scoreboard bench for line_loader
module tb_line_loader;
    import encoder_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    line_t         in_data;
    logic          in_par;
    logic [AW-1:0] cnt_value;
    logic          donee;
    logic          start;
    line_t         line_in;
    logic          busy;
    logic [7:0]    frame_cnt;
    logic          par_err;

    line_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_par    (in_par),
        .cnt_value (cnt_value),
        .donee     (donee),
        .start     (start),
        .line_in   (line_in),
        .busy      (busy),
        .frame_cnt (frame_cnt),
        .par_err   (par_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 0;

    // Reference model: a frame is a count of lines taken; once 64 are in,
    // the encoder owns the buffer until it reports done.
    line_t m_mem [64];
    bit    m_written [64];
    int    m_nlines = 0;
    bit    m_owned = 0;
    bit    m_start_due = 0;
    int    m_frames = 0;
    bit    m_perr = 0;
    int    m_starts = 0;

    line_t exp_q [$];
    line_t cur_frame [64];
    bit    have_frame = 0;
    int    dut_starts = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            m_nlines    = 0;
            m_owned     = 0;
            m_start_due = 0;
            m_frames    = 0;
            m_perr      = 0;
        end else if (m_start_due) begin
            m_start_due = 0;
        end else if (m_owned) begin
            if (donee) begin
                m_owned  = 0;
                m_frames = (m_frames + 1) % 256;
            end
        end else if (in_valid) begin
            m_mem[m_nlines]     = in_data;
            m_written[m_nlines] = 1;
            m_perr = ((m_nlines == 0) ? 1'b0 : m_perr) | ((^in_data) ^ in_par);
            m_nlines++;
            if (m_nlines == 64) begin
                for (int i = 0; i < 64; i++) exp_q.push_back(m_mem[i]);
                m_nlines    = 0;
                m_owned     = 1;
                m_start_due = 1;
                m_starts++;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("in_ready", 32'(in_ready), 32'(!m_owned));
            chk("busy", 32'(busy), 32'(m_owned));
            chk("start", 32'(start), 32'(m_start_due));
            chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
`ifdef LOADER_PARITY_EN
            chk("par_err", 32'(par_err), 32'(m_perr));
`else
            chk("par_err", 32'(par_err), 32'(0));
`endif
            if (start === 1'b1) begin
                dut_starts++;
                if (exp_q.size() < 64) begin
                    chk("start_without_frame", 32'(exp_q.size()), 32'(64));
                end else begin
                    for (int i = 0; i < 64; i++) cur_frame[i] = exp_q.pop_front();
                    have_frame = 1;
                end
            end
            if (busy === 1'b1 && have_frame) begin
                chk("frame_line", 32'(line_in), 32'(cur_frame[cnt_value]));
            end else if (m_written[cnt_value]) begin
                chk("line_in", 32'(line_in), 32'(m_mem[cnt_value]));
            end
        end
    end

    // Encoder stand-in: sweeps all addresses after start, then random ones,
    // then reports done; while idle it pokes random addresses and stray donee.
    initial begin
        int  k;
        int  n;
        bit  running;
        running   = 0;
        k         = 0;
        n         = 0;
        cnt_value = '0;
        donee     = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            donee = 1'b0;
            if (!rst) running = 0;
            if (!running && busy === 1'b1) begin
                running = 1;
                k = 0;
                n = $urandom_range(64, 90);
            end
            if (running) begin
                if (k < 64) cnt_value = AW'(k);
                else cnt_value = AW'($urandom);
                k++;
                if (k == n) begin
                    donee   = 1'b1;
                    running = 0;
                end
            end else begin
                cnt_value = AW'($urandom);
                if ($urandom_range(0, 7) == 0) donee = 1'b1;
            end
        end
    end

    task automatic send_line(input line_t d, input logic bad_par);
        bit done;
        done     = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_par   = (^d) ^ bad_par;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 32'(0), 32'(1));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (busy === 1'b0) ok = 1;
        end
        if (!ok) chk("idle_timeout", 32'(0), 32'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_par   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checking = 1;
        chk("reset_in_ready", 32'(in_ready), 32'(1));
        chk("reset_frame_cnt", 32'(frame_cnt), 32'(0));
        rst = 1'b1;

        // Full load of index values, then the next frame held against backpressure.
        for (int i = 0; i < 64; i++) send_line(line_t'(i), 1'b0);
        for (int i = 0; i < 64; i++) begin
            send_line(line_t'($urandom), (i == 7));
            idle(1);
        end
        wait_idle();

        // Partial frame discarded by reset, then a complete one.
        for (int i = 0; i < 30; i++) send_line(line_t'($urandom), 1'b0);
        pulse_reset();
        for (int i = 0; i < 64; i++) send_line(line_t'($urandom), 1'b0);
        wait_idle();

        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 64; i++) begin
                send_line(line_t'($urandom), ($urandom_range(0, 19) == 0));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        wait_idle();

        // Reset while the encoder owns the buffer.
        for (int i = 0; i < 64; i++) send_line(line_t'($urandom), 1'b0);
        idle(5);
        pulse_reset();
        idle(3);
        chk("rst_run_busy", 32'(busy), 32'(0));
        chk("rst_run_frame_cnt", 32'(frame_cnt), 32'(0));

        idle(4);
        checking = 0;
        chk("start_count", 32'(dut_starts), 32'(m_starts));
        chk("frames_drained", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/line_loader.md
# line_loader

Front-end stage feeding `encoder_top`. It accepts 64 lines of 25 bits over a valid/ready stream and stores them in a local 64×25 buffer. It pulses `start` to the encoder, then serves `line_in` by addressing the buffer with the encoder's `cnt_value`. It blocks new input until the encoder reports `donee`, then reopens for the next frame.

## Interface
- `LINE_W`, 25, width of one matrix line
- `DEPTH`, 64, lines per frame
- `AW`, 6, buffer address width (log2 DEPTH)
- `clk` input 1: single clock, rising edge
- `rst` input 1: synchronous, active-low reset
- `in_valid` input 1: upstream line valid
- `in_ready` output 1: loader can accept a line
- `in_data` input LINE_W: line payload
- `in_par` input 1: parity bit for `in_data`; only used with `LOADER_PARITY_EN`
- `cnt_value` input AW: encoder read address
- `donee` input 1: encoder finished frame
- `start` output 1: one-cycle start pulse to encoder
- `line_in` output LINE_W: buffer contents at `cnt_value`
- `busy` output 1: frame handed to encoder, not yet done
- `frame_cnt` output 8: completed frames, wraps 255→0
- `par_err` output 1: sticky parity error for current frame

## Operation
- States: LOAD, START, RUN.
- **LOAD**
  - `in_ready`=1.
  - A handshake (`in_valid`&`in_ready` at the edge) writes `in_data` to `buf[wr_ptr]` and increments `wr_ptr`.
  - Accepting the line with `wr_ptr`=63 moves to START, with `wr_ptr` wrapping to 0.
  - `donee` is ignored in LOAD.
- **START**
  - `start`=1 and `busy`=1 for exactly one cycle; `in_ready`=0.
  - Always moves to RUN.
- **RUN**
  - `busy`=1, `in_ready`=0.
  - On `donee`=1: move to LOAD and increment `frame_cnt`.
- `in_valid` while `in_ready`=0 is not accepted. Upstream must hold its data (standard valid/ready).
- `line_in` is an asynchronous read of `buf[cnt_value]` in every state.
- The buffer is never overwritten while `busy`=1.
- `wr_ptr` is 6-bit unsigned. `frame_cnt` is 8-bit modulo 256.
- **Reset** (`rst`=0 at an edge), including mid-frame or mid-RUN:
  - state=LOAD, `wr_ptr`=0, `frame_cnt`=0, `par_err`=0.
  - Buffer contents are not cleared. A partial frame is discarded.
- **Output values during/after reset:** `in_ready`=1, `start`=0, `busy`=0, `frame_cnt`=0, `par_err`=0. `line_in` is undefined until written.

## Timing
- `in_ready`, `start`, and `busy` are decoded from registered state (no combinational path from `in_valid`).
- 64th line accepted at edge N: `start`=1 during cycle N..N+1, and state is RUN from edge N+1.
- Data written at edge N is readable on `line_in` from cycle N onward.
- `donee` sampled at edge M: `in_ready`=1 and `busy`=0 from edge M onward. Earliest next acceptance is at edge M+1.
- Minimum frame period is 64 + 1 + encoder run cycles.
- Back-to-back input with `in_valid` held high loads one line per cycle, 64 cycles.

## Configuration
- Macro: `LOADER_PARITY_EN`.
- **Defined:**
  - Every accepted line is checked for even parity (XOR of `in_data` and `in_par` must be 0).
  - A mismatch sets `par_err` on the accepting edge. It stays set through RUN and clears on the first acceptance of the next frame, unless that line also fails.
  - Data is stored regardless of parity.
- **Undefined:** `in_par` is ignored and `par_err` is tied to 0.

## Structure
- Shared package `encoder_pkg` holds:
  - `LINE_W`, `DEPTH`, `AW` constants
  - `loader_state_t` enum {LOAD, START, RUN}
  - the line typedef `line_t` = logic [LINE_W-1:0]
- One sub-module, `line_buffer`: DEPTH×LINE_W storage with synchronous write (`we`, `waddr`, `wdata`) and asynchronous read (`raddr` → `rdata`).
- FSM, pointer, counters and parity logic live in `line_loader`.

## Test plan
- **Full load:** after reset, stream lines 0..63 with `in_data`=index. Expect one `start` pulse the cycle after the 64th handshake, `busy`=1, and `in_ready`=0. Sweeping `cnt_value` 0..63 gives `line_in`=0..63.
- **Backpressure:** hold `in_valid`=1 with new data during RUN. Expect no writes, and `line_in` at `cnt_value`=5 stays 5. Pulse `donee`: `in_ready`=1 next cycle, `frame_cnt`=1.
- **Gapped input:** drive valid on alternate cycles. Expect `start` only after exactly 64 handshakes, with no early `start`.
- **Mid-frame reset:** load 30 lines, assert `rst`=0 for one edge, then load 64 lines. Expect `start` after 64 further handshakes, not 34; `frame_cnt`=0 until the first `donee`.
- **Spurious `donee`:** pulse `donee` in LOAD after 10 lines. Expect no state change and `frame_cnt` unchanged.
- **Parity (`LOADER_PARITY_EN`):** send line 7 with wrong `in_par`. Expect `par_err`=1 from that edge through RUN, cleared when line 0 of the next frame is accepted with good parity. Without the macro, `par_err` stays 0.
